// File: rtl/signal_history_pkg.sv
// Shared constants and slice-offset helpers for the signal_history block.
//   tap_w(depth)      : width of a tap select able to address 0..depth
//   TAP_LIVE          : tap-select value that passes the live input through
//   chan_off / stage_off : bit offsets into the packed din/sel_data/taps buses
package signal_history_pkg;

  localparam int unsigned TAP_LIVE = 0;

  function automatic int unsigned tap_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Offset of channel c in a CHANNELS*WIDTH bus.
  function automatic int unsigned chan_off(input int unsigned c, input int unsigned width);
    return c * width;
  endfunction

  // Offset of channel c, stage k (1-based) in a CHANNELS*DEPTH*WIDTH bus.
  function automatic int unsigned stage_off(input int unsigned c, input int unsigned k,
                                            input int unsigned depth, input int unsigned width);
    return (c * depth + k - 1) * width;
  endfunction

endpackage

// File: rtl/history_channel.sv
// One channel of signal_history: DEPTH-stage shift chain, runtime tap mux and
// change/stability detection.
// Ports:
//   clk, reset   clock and async active-low reset
//   en, flush    capture enable and synchronous clear (flush wins)
//   din          live sample
//   tap_sel      0 = din, k = stage k, >DEPTH = 0
//   fill_nz      at least one valid stage (shared fill counter != 0)
//   full         all stages valid (shared)
//   taps         stage k at [(k-1)*WIDTH +: WIDTH]
//   sel_data     selected tap value
//   changed      din differs from p1 while p1 is valid
//   stable       full and din equals every stage
module history_channel
  import signal_history_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAP_W = tap_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  input  logic [TAP_W-1:0]         tap_sel,
  input  logic                     fill_nz,
  input  logic                     full,
  output logic [DEPTH*WIDTH-1:0]   taps,
  output logic [WIDTH-1:0]         sel_data,
  output logic                     changed,
  output logic                     stable
);

  logic [WIDTH-1:0] stage [DEPTH];
  logic             all_eq;

  // Shift chain: stage[0] is p1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else if (en) begin
      stage[0] <= din;
      for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  // Flatten stages onto the taps bus.
  always_comb begin
    taps = '0;
    for (int k = 0; k < DEPTH; k++) taps[k*WIDTH +: WIDTH] = stage[k];
  end

  // Tap mux; out-of-range selects fall through to zero.
  always_comb begin
    sel_data = '0;
    if (tap_sel == TAP_W'(TAP_LIVE)) sel_data = din;
    for (int k = 1; k <= DEPTH; k++) begin
      if (tap_sel == TAP_W'(k)) sel_data = stage[k-1];
    end
  end

  // Change/stability against the stored history.
  always_comb begin
    all_eq = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      if (din != stage[k]) all_eq = 1'b0;
    end
    changed = fill_nz && (din != stage[0]);
    stable  = full && all_eq;
  end

endmodule

// File: rtl/signal_history.sv
// DEPTH-deep history of CHANNELS independent WIDTH-bit signals with capture
// enable, sync flush, fill tracking, runtime tap select and change/stable flags.
// Ports:
//   clk, reset   clock and async active-low reset
//   en, flush    shift history / clear history and fill (flush wins)
//   din          channel c at [c*WIDTH +: WIDTH]
//   tap_sel      0 = live din, k = pk, >DEPTH flagged via sel_err
//   taps         ch c stage k at [(c*DEPTH+k-1)*WIDTH +: WIDTH]
//   sel_data     per-channel selected tap
//   sel_err      tap_sel > DEPTH
//   fill, full   valid-stage count (saturating) and fill == DEPTH
//   changed      per channel din != p1 while fill >= 1
//   stable       per channel full and din equal to every stage
module signal_history
  import signal_history_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned TAP_W    = tap_w(DEPTH)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en,
  input  logic                              flush,
  input  logic [CHANNELS*WIDTH-1:0]         din,
  input  logic [TAP_W-1:0]                  tap_sel,
  output logic [CHANNELS*DEPTH*WIDTH-1:0]   taps,
  output logic [CHANNELS*WIDTH-1:0]         sel_data,
  output logic                              sel_err,
  output logic [TAP_W-1:0]                  fill,
  output logic                              full,
  output logic [CHANNELS-1:0]               changed,
  output logic [CHANNELS-1:0]               stable
);

  logic [TAP_W-1:0] fill_nxt;
  logic             fill_nz;

  // Saturating fill count; flush returns it to empty.
  always_comb begin
    fill_nxt = fill;
    if (flush) begin
      fill_nxt = '0;
    end else if (en && (fill != TAP_W'(DEPTH))) begin
      fill_nxt = fill + TAP_W'(1);
    end
  end

  // full is registered alongside fill so it never lags the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill <= '0;
      full <= 1'b0;
    end else begin
      fill <= fill_nxt;
      full <= (fill_nxt == TAP_W'(DEPTH));
    end
  end

  assign fill_nz = (fill != '0);
  // Extra MSB keeps the compare meaningful when TAP_W can only just hold DEPTH.
  assign sel_err = ({1'b0, tap_sel} > (TAP_W+1)'(DEPTH));

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    history_channel #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .TAP_W (TAP_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .flush    (flush),
      .din      (din[chan_off(c, WIDTH) +: WIDTH]),
      .tap_sel  (tap_sel),
      .fill_nz  (fill_nz),
      .full     (full),
      .taps     (taps[stage_off(c, 1, DEPTH, WIDTH) +: DEPTH*WIDTH]),
      .sel_data (sel_data[chan_off(c, WIDTH) +: WIDTH]),
      .changed  (changed[c]),
      .stable   (stable[c])
    );
  end

endmodule
